// File: rtl/div_seq_32_pkg.sv
// div_seq_32_pkg: state encoding and sizing shared by the sequential divider
package div_seq_32_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_WIDTH = $clog2(ITER_COUNT);
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITER_COUNT - 1);
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ITER = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;
endpackage

// File: rtl/div_seq_32_rc_add_sub.sv
// div_seq_32_rc_add_sub: 32-bit ripple-carry adder/subtractor; sna=1 gives a - b, co=1 means no borrow
module div_seq_32_rc_add_sub
    import div_seq_32_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sna,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  co
);
    logic [DATA_WIDTH:0] c;
    assign c[0] = sna;
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        logic bx;
        assign bx = b[i] ^ sna;
        assign y[i] = a[i] ^ bx ^ c[i];
        assign c[i+1] = (a[i] & bx) | (c[i] & (a[i] ^ bx));
    end
    assign co = c[DATA_WIDTH];
endmodule

// File: rtl/div_seq_32.sv
// div_seq_32: sequential 32-bit restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the SIGNED port and two's-complement (truncating) division.
module div_seq_32
    import div_seq_32_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
`ifdef DIV_SIGNED_EN
    input  logic                  SIGNED,
`endif
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] R,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DIV0
);
    div_state_t state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] p, d, dvs, diff, p_nxt, d_nxt, a_mag, b_mag, q_fin, r_fin;
    logic div0_r, co, win, accept, last, b_zero, busy_nxt;

    // d doubles as dividend shifter and quotient collector
    div_seq_32_rc_add_sub u_trial (
        .a  ({p[DATA_WIDTH-2:0], d[DATA_WIDTH-1]}),
        .b  (dvs),
        .sna(1'b1),
        .y  (diff),
        .co (co)
    );

    always_comb begin
        win = p[DATA_WIDTH-1] | co;
        p_nxt = win ? diff : {p[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};
        d_nxt = {d[DATA_WIDTH-2:0], win};
    end

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, a_sgn, b_sgn, n0_co, n1_co;
    logic [DATA_WIDTH-1:0] n0, n1;
    // negators take operands at capture and the final quotient/remainder on the last iteration
    div_seq_32_rc_add_sub u_neg0 (
        .a  ({DATA_WIDTH{1'b0}}),
        .b  (state == DIV_ITER ? d_nxt : A),
        .sna(1'b1),
        .y  (n0),
        .co (n0_co)
    );
    div_seq_32_rc_add_sub u_neg1 (
        .a  ({DATA_WIDTH{1'b0}}),
        .b  (state == DIV_ITER ? p_nxt : B),
        .sna(1'b1),
        .y  (n1),
        .co (n1_co)
    );
    always_comb begin
        a_neg = SIGNED & A[DATA_WIDTH-1];
        b_neg = SIGNED & B[DATA_WIDTH-1];
        b_zero = n1_co;
        a_mag = a_neg ? n0 : A;
        b_mag = b_neg ? n1 : B;
        q_fin = (a_sgn ^ b_sgn) && !n0_co ? n0 : d_nxt;
        r_fin = a_sgn ? n1 : p_nxt;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_sgn <= 1'b0;
            b_sgn <= 1'b0;
        end else if (accept) begin
            a_sgn <= a_neg;
            b_sgn <= b_neg;
        end
    end
`else
    always_comb begin
        b_zero = B == '0;
        a_mag = A;
        b_mag = B;
        q_fin = d_nxt;
        r_fin = p_nxt;
    end
`endif

    always_comb begin
        accept = START && state != DIV_ITER;
        last = state == DIV_ITER && cnt == LAST_ITER;
        state_nxt = accept ? (b_zero ? DIV_DONE : DIV_ITER) :
                    last ? DIV_DONE :
                    state == DIV_DONE ? DIV_IDLE : state;
        busy_nxt = state_nxt == DIV_ITER || last;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= DIV_IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            p <= '0;
            d <= '0;
            dvs <= '0;
            div0_r <= 1'b0;
            Q <= '0;
            R <= '0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            DIV0 <= 1'b0;
        end else begin
            BUSY <= busy_nxt;
            DONE <= state == DIV_DONE;
            if (state == DIV_DONE) begin
                Q <= d;
                R <= p;
                DIV0 <= div0_r;
            end
            if (accept) begin
                cnt <= '0;
                dvs <= b_mag;
                d <= b_zero ? '1 : a_mag;
                p <= b_zero ? A : '0;
                div0_r <= b_zero;
            end else if (state == DIV_ITER) begin
                cnt <= cnt + CNT_WIDTH'(1);
                d <= last ? q_fin : d_nxt;
                p <= last ? r_fin : p_nxt;
            end
        end
    end
endmodule
